// File: rtl/diff_sq_pipe_pkg.sv
// Shared helpers for the difference-of-squares pipeline: operand extension
// and the saturation bounds of the result range. Functions return fixed
// maximum-width vectors that callers slice down to their own width, so N is
// limited to N_MAX-2.
package diff_sq_pkg;

  localparam int N_MAX  = 128;
  localparam int PW_MAX = 2 * N_MAX + 2;

  typedef logic signed [PW_MAX-1:0] wide_t;
  typedef logic [N_MAX:0]           ext_t;

  // Largest representable result: 2^(n-1)-1 signed, 2^n-1 unsigned.
  function automatic wide_t sat_hi(input int n, input bit sgn);
    wide_t one;
    one = wide_t'(1);
    return sgn ? (one <<< (n - 1)) - one : (one <<< n) - one;
  endfunction

  // Smallest representable result: -2^(n-1) signed, 0 unsigned.
  function automatic wide_t sat_lo(input int n, input bit sgn);
    wide_t one;
    one = wide_t'(1);
    return sgn ? -(one <<< (n - 1)) : '0;
  endfunction

  // Extends the low n bits of x to the full ext_t width. Bits of x at or
  // above n are ignored, so the caller may pass a zero-padded operand.
  function automatic ext_t ext(input logic [N_MAX-1:0] x, input int n, input bit sgn);
    logic [N_MAX-1:0] shifted;
    ext_t             mask;
    logic             msb;
    shifted = x >> (n - 1);
    msb     = sgn & shifted[0];
    mask    = {(N_MAX + 1){1'b1}} << n;
    return ({1'b0, x} & ~mask) | (msb ? mask : '0);
  endfunction

endpackage

// File: rtl/diff_sq_pipe_if.sv
// Stream bundle around diff_sq_pipe, as seen by the bench or a parent block.
// Handshake: a beat moves on a rising clock edge where valid && ready; valid
// may be raised without waiting for ready, ready may depend combinationally
// on the far side's ready, and nothing else accepts a beat.
interface diff_sq_pipe_if #(
  parameter int N     = 32,
  parameter int CNT_W = 16
) ();
  logic [N-1:0]     a;
  logic [N-1:0]     b;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     r;
  logic             ovf;
  logic             out_valid;
  logic             out_ready;
  logic             clr;
  logic [CNT_W-1:0] ovf_cnt;

  // Master sources operands and consumes results.
  modport master (
    output a, b, in_valid, out_ready, clr,
    input  in_ready, r, ovf, out_valid, ovf_cnt
  );

  // Slave is the pipeline itself.
  modport slave (
    input  a, b, in_valid, out_ready, clr,
    output in_ready, r, ovf, out_valid, ovf_cnt
  );
endinterface

// File: rtl/diff_sq_stage.sv
// Generic valid/ready register slice. Loads whenever it is empty or its
// downstream is taking the current beat, so bubbles collapse and ready
// propagates combinationally back through a chain of slices.
module diff_sq_stage #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] data_o
);
  logic         v_q, v_d;
  logic [W-1:0] data_q, data_d;

  assign ready_o = !v_q || ready_i;

  // Next state: advance on ready_o; data only captured for a real beat.
  always_comb begin
    v_d    = v_q;
    data_d = data_q;
    if (ready_o) begin
      v_d = valid_i;
      if (valid_i) data_d = data_i;
    end
  end

  // Valid and data registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v_q    <= 1'b0;
      data_q <= '0;
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
    end
  end

  assign valid_o = v_q;
  assign data_o  = data_q;
endmodule

// File: rtl/diff_sq_pipe.sv
// Three-stage R = (A+B)*(A-B) pipeline with backpressure, optional signed
// operands, saturating or wrapping result, overflow flag and a saturating
// count of delivered overflowing results.
module diff_sq_pipe
  import diff_sq_pkg::*;
#(
  parameter int N      = 32,
  parameter int SIGNED = 0,
  parameter int SAT    = 1,
  parameter int CNT_W  = 16
) (
  input  logic             csi_clk,
  input  logic             rsi_reset_n,
  input  logic [N-1:0]     coe_A,
  input  logic [N-1:0]     coe_B,
  input  logic             coe_in_valid,
  output logic             coe_in_ready,
  output logic [N-1:0]     coe_R,
  output logic             coe_ovf,
  output logic             coe_out_valid,
  input  logic             coe_out_ready,
  input  logic             coe_clr,
  output logic [CNT_W-1:0] coe_ovf_cnt
);
  // The unsigned sum of two N-bit operands needs N+1 magnitude bits, so the
  // sum is carried one bit wider than the difference to keep the product exact.
  localparam int SW = N + 2;
  localparam int DW = N + 1;
  localparam int PW = 2 * N + 2;

  // ---------------- S0: operand register ----------------
  logic            s0_valid, s0_ready;
  logic [2*N-1:0]  s0_data;
  logic [N-1:0]    a0, b0;

  diff_sq_stage #(.W(2 * N)) u_s0 (
    .clk_i   (csi_clk),
    .rst_ni  (rsi_reset_n),
    .valid_i (coe_in_valid),
    .ready_o (coe_in_ready),
    .data_i  ({coe_A, coe_B}),
    .valid_o (s0_valid),
    .ready_i (s0_ready),
    .data_o  (s0_data)
  );

  assign {a0, b0} = s0_data;

  ext_t                 a_x, b_x;
  logic signed [SW-1:0] s_c;
  logic signed [DW-1:0] d_c;

  assign a_x = ext(N_MAX'(a0), N, SIGNED != 0);
  assign b_x = ext(N_MAX'(b0), N, SIGNED != 0);
  assign s_c = a_x[SW-1:0] + b_x[SW-1:0];
  assign d_c = a_x[DW-1:0] - b_x[DW-1:0];

  // ---------------- S1: sum / difference register ----------------
  logic               s1_valid, s1_ready;
  logic [SW+DW-1:0]   s1_data;
  logic signed [SW-1:0] s1;
  logic signed [DW-1:0] d1;

  diff_sq_stage #(.W(SW + DW)) u_s1 (
    .clk_i   (csi_clk),
    .rst_ni  (rsi_reset_n),
    .valid_i (s0_valid),
    .ready_o (s0_ready),
    .data_i  ({s_c, d_c}),
    .valid_o (s1_valid),
    .ready_i (s1_ready),
    .data_o  (s1_data)
  );

  assign {s1, d1} = s1_data;

  // Product and range check. |p| < 2^(2N+1) for every operand pair, so the
  // PW-bit signed product is exact.
  logic signed [PW-1:0] p_c, hi_c, lo_c;
  wide_t                hi_w, lo_w;
  logic                 ovf_c;
  logic [N-1:0]         r_c;

  assign hi_w  = sat_hi(N, SIGNED != 0);
  assign lo_w  = sat_lo(N, SIGNED != 0);
  assign hi_c  = hi_w[PW-1:0];
  assign lo_c  = lo_w[PW-1:0];
  assign p_c   = PW'(s1) * PW'(d1);
  assign ovf_c = (p_c > hi_c) || (p_c < lo_c);

  // Result select: clamp to the nearer bound when saturating, else wrap.
  always_comb begin
    r_c = p_c[N-1:0];
    if ((SAT != 0) && ovf_c) r_c = (p_c > hi_c) ? hi_c[N-1:0] : lo_c[N-1:0];
  end

  // ---------------- S2: result register ----------------
  logic [N:0] s2_data;

  diff_sq_stage #(.W(N + 1)) u_s2 (
    .clk_i   (csi_clk),
    .rst_ni  (rsi_reset_n),
    .valid_i (s1_valid),
    .ready_o (s1_ready),
    .data_i  ({ovf_c, r_c}),
    .valid_o (coe_out_valid),
    .ready_i (coe_out_ready),
    .data_o  (s2_data)
  );

  assign coe_R   = s2_data[N-1:0];
  assign coe_ovf = s2_data[N];

  // ---------------- overflow event counter ----------------
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear wins over a same-cycle increment; increments stop at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (coe_clr) begin
      cnt_d = '0;
    end else if (coe_out_valid && coe_out_ready && coe_ovf && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) cnt_q <= '0;
    else              cnt_q <= cnt_d;
  end

  assign coe_ovf_cnt = cnt_q;

  // Upper bits of the wide helper results are not needed at this width.
  logic unused_bits;
  assign unused_bits = ^{a_x[N_MAX:SW], b_x[N_MAX:SW], hi_w[PW_MAX-1:PW], lo_w[PW_MAX-1:PW]};
endmodule

// File: tb/tb_diff_sq_pipe.sv
// Bench for diff_sq_pipe: three N=8 instances share one input stream
// (u0 unsigned saturating with a 2-bit counter, u1 unsigned wrapping,
// u2 signed saturating) and are checked against an integer model.
module tb_diff_sq_pipe;
  localparam int N_ITEMS     = 10000;
  localparam int RAND_BUDGET = 60000;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       in_valid  = 1'b0;
  logic       out_ready = 1'b0;
  logic       clr       = 1'b0;

  int errors = 0;
  int checks = 0;

  // Each entry packs {r0,ovf0, r1,ovf1, r2,ovf2} for the three instances.
  logic [26:0] exp_q[$];

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  diff_sq_pipe_if #(.N(8), .CNT_W(2))  if0 ();
  diff_sq_pipe_if #(.N(8), .CNT_W(16)) if1 ();
  diff_sq_pipe_if #(.N(8), .CNT_W(16)) if2 ();

  assign if0.a = a;  assign if0.b = b;  assign if0.in_valid = in_valid;
  assign if0.out_ready = out_ready;  assign if0.clr = clr;
  assign if1.a = a;  assign if1.b = b;  assign if1.in_valid = in_valid;
  assign if1.out_ready = out_ready;  assign if1.clr = clr;
  assign if2.a = a;  assign if2.b = b;  assign if2.in_valid = in_valid;
  assign if2.out_ready = out_ready;  assign if2.clr = clr;

  diff_sq_pipe #(.N(8), .SIGNED(0), .SAT(1), .CNT_W(2)) u0 (
    .csi_clk(clk), .rsi_reset_n(rst_n), .coe_A(if0.a), .coe_B(if0.b),
    .coe_in_valid(if0.in_valid), .coe_in_ready(if0.in_ready), .coe_R(if0.r),
    .coe_ovf(if0.ovf), .coe_out_valid(if0.out_valid), .coe_out_ready(if0.out_ready),
    .coe_clr(if0.clr), .coe_ovf_cnt(if0.ovf_cnt));

  diff_sq_pipe #(.N(8), .SIGNED(0), .SAT(0), .CNT_W(16)) u1 (
    .csi_clk(clk), .rsi_reset_n(rst_n), .coe_A(if1.a), .coe_B(if1.b),
    .coe_in_valid(if1.in_valid), .coe_in_ready(if1.in_ready), .coe_R(if1.r),
    .coe_ovf(if1.ovf), .coe_out_valid(if1.out_valid), .coe_out_ready(if1.out_ready),
    .coe_clr(if1.clr), .coe_ovf_cnt(if1.ovf_cnt));

  diff_sq_pipe #(.N(8), .SIGNED(1), .SAT(1), .CNT_W(16)) u2 (
    .csi_clk(clk), .rsi_reset_n(rst_n), .coe_A(if2.a), .coe_B(if2.b),
    .coe_in_valid(if2.in_valid), .coe_in_ready(if2.in_ready), .coe_R(if2.r),
    .coe_ovf(if2.ovf), .coe_out_valid(if2.out_valid), .coe_out_ready(if2.out_ready),
    .coe_clr(if2.clr), .coe_ovf_cnt(if2.ovf_cnt));

  logic [26:0] obs;
  logic [33:0] cnt_obs;
  logic [2:0]  ir_obs, ov_obs;
  assign obs     = {if0.r, if0.ovf, if1.r, if1.ovf, if2.r, if2.ovf};
  assign cnt_obs = {if0.ovf_cnt, if1.ovf_cnt, if2.ovf_cnt};
  assign ir_obs  = {if0.in_ready, if1.in_ready, if2.in_ready};
  assign ov_obs  = {if0.out_valid, if1.out_valid, if2.out_valid};

  // ---------------- reference model ----------------
  function automatic logic [26:0] ref_model(input logic [7:0] x, input logic [7:0] y);
    int ux, uy, sx, sy, pu, ps;
    logic [7:0] r0, r1, r2;
    logic o0, o2;
    ux = x;  uy = y;
    sx = $signed(x);  sy = $signed(y);
    pu = (ux + uy) * (ux - uy);
    ps = (sx + sy) * (sx - sy);
    o0 = (pu < 0) || (pu > 255);
    r0 = (pu < 0) ? 8'd0 : (pu > 255) ? 8'd255 : pu[7:0];
    r1 = pu[7:0];
    o2 = (ps < -128) || (ps > 127);
    r2 = (ps < -128) ? 8'h80 : (ps > 127) ? 8'h7f : ps[7:0];
    return {r0, o0, r1, o0, r2, o2};
  endfunction

  function automatic logic [7:0] pick();
    logic [7:0] v;
    v = 8'($urandom_range(0, 255));
    if ($urandom_range(0, 4) == 0) begin
      case ($urandom_range(0, 3))
        0:       v = 8'h00;
        1:       v = 8'h7f;
        2:       v = 8'h80;
        default: v = 8'hff;
      endcase
    end
    return v;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ov_obs !== 3'b000) begin errors++; $display("FAIL reset_out_valid: got %b exp 000", ov_obs); end
    checks++; if (obs !== 27'd0) begin errors++; $display("FAIL reset_r_ovf: got %h exp 0", obs); end
    checks++; if (cnt_obs !== 34'd0) begin errors++; $display("FAIL reset_cnt: got %h exp 0", cnt_obs); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (ir_obs !== 3'b111) begin errors++; $display("FAIL reset_in_ready: got %b exp 111", ir_obs); end
    checks++; if (ov_obs !== 3'b000) begin errors++; $display("FAIL post_reset_out_valid: got %b exp 000", ov_obs); end
  endtask

  task automatic test_directed();
    logic [7:0] da[6];
    logic [7:0] db[6];
    logic [8:0] e0[3];
    logic [8:0] e1[3];
    logic [8:0] e2[3];
    int k = 0;
    da = '{8'd10, 8'd3, 8'd200, 8'd251, 8'd128, 8'd127};
    db = '{8'd3, 8'd10, 8'd0, 8'd3, 8'd128, 8'd128};
    e0 = '{{8'd91, 1'b0}, {8'd0, 1'b1}, {8'd255, 1'b1}};
    e1 = '{{8'd91, 1'b0}, {8'hA5, 1'b1}, {8'd64, 1'b1}};
    e2 = '{{8'd16, 1'b0}, {8'd0, 1'b0}, {8'h80, 1'b1}};
    out_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk);
      #1;
      if (c < 6) begin a = da[c]; b = db[c]; in_valid = 1'b1; end
      else in_valid = 1'b0;
      @(negedge clk);
      if (c < 6) begin
        checks++; if (ir_obs !== 3'b111) begin errors++; $display("FAIL dir_in_ready c=%0d: got %b exp 111", c, ir_obs); end
      end
      if (if0.out_valid === 1'b1 && k < 6) begin
        checks++; if ((c - 3) != k) begin errors++; $display("FAIL dir_latency item %0d: got cycle %0d exp %0d", k, c, k + 3); end
        if (k < 3) begin
          checks++; if ({if0.r, if0.ovf} !== e0[k]) begin errors++; $display("FAIL dir_u_sat item %0d: got %h exp %h", k, {if0.r, if0.ovf}, e0[k]); end
          checks++; if ({if1.r, if1.ovf} !== e1[k]) begin errors++; $display("FAIL dir_u_wrap item %0d: got %h exp %h", k, {if1.r, if1.ovf}, e1[k]); end
        end else begin
          checks++; if ({if2.r, if2.ovf} !== e2[k-3]) begin errors++; $display("FAIL dir_s_sat item %0d: got %h exp %h", k, {if2.r, if2.ovf}, e2[k-3]); end
        end
        k++;
      end
      if (c == 6) begin
        checks++; if (if1.ovf_cnt !== 16'd2) begin errors++; $display("FAIL dir_cnt_wrap: got %0d exp 2", if1.ovf_cnt); end
        checks++; if (if0.ovf_cnt !== 2'd2) begin errors++; $display("FAIL dir_cnt_sat: got %0d exp 2", if0.ovf_cnt); end
      end
    end
    checks++; if (k != 6) begin errors++; $display("FAIL dir_count: got %0d exp 6", k); end
  endtask

  task automatic test_backpressure();
    logic [7:0] ba[4];
    logic [7:0] bb[4];
    logic [26:0] e;
    int acc = 0;
    int got = 0;
    ba = '{8'd10, 8'd3, 8'd200, 8'd17};
    bb = '{8'd3, 8'd10, 8'd0, 8'd5};
    e = '0;
    exp_q.delete();
    out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (acc < 4) begin a = ba[acc]; b = bb[acc]; in_valid = 1'b1; end
      else in_valid = 1'b0;
      @(negedge clk);
      if (in_valid && if0.in_ready) begin exp_q.push_back(ref_model(a, b)); acc++; end
    end
    checks++; if (acc != 3) begin errors++; $display("FAIL bp_accepts: got %0d exp 3", acc); end
    checks++; if (ir_obs !== 3'b000) begin errors++; $display("FAIL bp_in_ready_full: got %b exp 000", ir_obs); end
    if (exp_q.size() > 0) e = exp_q[0];
    checks++; if (obs !== e || if0.out_valid !== 1'b1) begin errors++; $display("FAIL bp_stalled_head: got %h v=%b exp %h v=1", obs, if0.out_valid, e); end
    @(posedge clk);
    #1;
    checks++; if (obs !== e) begin errors++; $display("FAIL bp_hold: got %h exp %h", obs, e); end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && got < 4; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checks++; if (ir_obs !== 3'b111) begin errors++; $display("FAIL bp_pop_push: got %b exp 111", ir_obs); end
      end
      if (if0.out_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL bp_extra_result: got %h exp none", obs); end
        else begin
          e = exp_q.pop_front();
          if (obs !== e) begin errors++; $display("FAIL bp_order item %0d: got %h exp %h", got, obs, e); end
        end
        got++;
      end
      if (in_valid && if0.in_ready) begin exp_q.push_back(ref_model(a, b)); acc++; end
      @(posedge clk);
      #1;
      if (acc >= 4) in_valid = 1'b0;
      else begin a = ba[acc]; b = bb[acc]; end
    end
    checks++; if (got != 4 || acc != 4) begin errors++; $display("FAIL bp_drain: got %0d/%0d exp 4/4", got, acc); end
    @(negedge clk);
    checks++; if (ov_obs !== 3'b000) begin errors++; $display("FAIL bp_no_dup: got %b exp 000", ov_obs); end
  endtask

  task automatic test_reset_midflight();
    logic [26:0] e;
    int acc = 0;
    int seen = 0;
    exp_q.delete();
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (acc < 3) begin a = pick(); b = pick(); in_valid = 1'b1; end
      else in_valid = 1'b0;
      @(negedge clk);
      if (in_valid && if0.in_ready) acc++;
    end
    checks++; if (acc != 3 || ov_obs !== 3'b111) begin errors++; $display("FAIL rst_fill: got %0d v=%b exp 3 v=111", acc, ov_obs); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (ov_obs !== 3'b000) begin errors++; $display("FAIL rst_async_valid: got %b exp 000", ov_obs); end
    checks++; if (obs !== 27'd0) begin errors++; $display("FAIL rst_async_data: got %h exp 0", obs); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) begin a = pick(); b = pick(); in_valid = 1'b1; end
      else in_valid = 1'b0;
      @(negedge clk);
      if (c == 0) begin
        checks++; if (ir_obs !== 3'b111) begin errors++; $display("FAIL rst_in_ready: got %b exp 111", ir_obs); end
        exp_q.push_back(ref_model(a, b));
      end
      if (if0.out_valid === 1'b1) begin
        checks++;
        if (c != 3) begin errors++; $display("FAIL rst_stale_or_latency: got valid at cycle %0d exp 3", c); end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          checks++; if (obs !== e) begin errors++; $display("FAIL rst_first_value: got %h exp %h", obs, e); end
        end
        seen++;
      end
    end
    checks++; if (seen != 1) begin errors++; $display("FAIL rst_result_count: got %0d exp 1", seen); end
  endtask

  task automatic test_counter();
    bit done = 0;
    @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    checks++; if (cnt_obs !== 34'd0) begin errors++; $display("FAIL cnt_clear: got %h exp 0", cnt_obs); end
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (c < 5) begin a = 8'd3; b = 8'd10; in_valid = 1'b1; end
      else in_valid = 1'b0;
    end
    @(negedge clk);
    checks++; if (if0.ovf_cnt !== 2'd3) begin errors++; $display("FAIL cnt_saturate: got %0d exp 3", if0.ovf_cnt); end
    checks++; if (if1.ovf_cnt !== 16'd5) begin errors++; $display("FAIL cnt_wide: got %0d exp 5", if1.ovf_cnt); end
    checks++; if (if2.ovf_cnt !== 16'd0) begin errors++; $display("FAIL cnt_signed_none: got %0d exp 0", if2.ovf_cnt); end
    @(posedge clk);
    #1;
    a = 8'd3; b = 8'd10; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int c = 0; c < 10 && !done; c++) begin
      @(negedge clk);
      if (if0.out_valid === 1'b1) begin clr = 1'b1; done = 1; end
    end
    checks++; if (!done) begin errors++; $display("FAIL cnt_clr_wait: got no result exp one within 10 cycles"); end
    @(posedge clk);
    #1;
    clr = 1'b0;
    checks++; if (if0.ovf_cnt !== 2'd0 || if1.ovf_cnt !== 16'd0) begin errors++; $display("FAIL cnt_clr_priority: got %0d/%0d exp 0/0", if0.ovf_cnt, if1.ovf_cnt); end
  endtask

  task automatic test_random();
    logic [1:0]  m0 = '0;
    logic [15:0] m1 = '0;
    logic [15:0] m2 = '0;
    logic [26:0] e;
    logic        exp_ir;
    bit          popped;
    int got = 0;
    int sent = 0;
    int cyc = 0;
    e = '0;
    in_valid = 1'b0; clr = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    while (got < N_ITEMS && cyc < RAND_BUDGET) begin
      @(posedge clk);
      #1;
      in_valid  = (sent < N_ITEMS) && ($urandom_range(0, 3) != 0);
      a         = pick();
      b         = pick();
      out_ready = ($urandom_range(0, 3) != 0);
      clr       = ($urandom_range(0, 63) == 0);
      @(negedge clk);
      cyc++;
      checks++; if (cnt_obs !== {m0, m1, m2}) begin errors++; $display("FAIL rnd_cnt cyc %0d: got %h exp %h", cyc, cnt_obs, {m0, m1, m2}); end
      exp_ir = (exp_q.size() < 3) || out_ready;
      checks++; if (ir_obs !== {3{exp_ir}}) begin errors++; $display("FAIL rnd_in_ready cyc %0d: got %b exp %b", cyc, ir_obs, {3{exp_ir}}); end
      popped = 0;
      if (if0.out_valid === 1'b1 && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL rnd_spurious cyc %0d: got %h exp none", cyc, obs); end
        else begin
          e = exp_q.pop_front();
          popped = 1;
          if (obs !== e) begin errors++; $display("FAIL rnd_result item %0d: got %h exp %h", got, obs, e); end
        end
        got++;
      end
      if (in_valid && if0.in_ready) begin exp_q.push_back(ref_model(a, b)); sent++; end
      if (clr) begin
        m0 = '0; m1 = '0; m2 = '0;
      end else if (popped) begin
        if (e[18] && m0 != 2'd3)     m0 = m0 + 2'd1;
        if (e[9]  && m1 != 16'hffff) m1 = m1 + 16'd1;
        if (e[0]  && m2 != 16'hffff) m2 = m2 + 16'd1;
      end
    end
    checks++; if (got != N_ITEMS) begin errors++; $display("FAIL rnd_timeout: got %0d results exp %0d", got, N_ITEMS); end
    in_valid = 1'b0; clr = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5ms;
    $display("FAIL watchdog: got no finish exp finish before 5ms");
    $fatal(1, "watchdog expired");
  end

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midflight();
    test_counter();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
